avm_copy_master: RTL and testbench
==================================

Name: avm_copy_master

Overview:
- Avalon-MM master (initiator) that copies a block of words from a source region to a destination region in memory.
- Driven by the accelerator control registers: START, source address, destination address and word count come from the slave register outputs. DONE feeds back into the status bit of that register.
- Sits between the register slave and the system interconnect. Issues one read then one write per word, with no outstanding transactions.

Parameters:
- AVM_AVALONMASTER_DATA_WIDTH, 32, data bus width in bits; byte address stride = DATA_WIDTH/8.
- AVM_AVALONMASTER_ADDRESS_WIDTH, 32, byte-address width.
- LENGTH_WIDTH, 16, width of the word-count input.

Ports:
- CSI_CLOCK_CLK  in  1  system clock; all logic on rising edge.
- CSI_CLOCK_RESET_N  in  1  reset, synchronous, active-low.
- START  in  1  level request (register bit 0).
- SRC_ADDR  in  ADDRESS_WIDTH  source byte address, word aligned.
- DST_ADDR  in  ADDRESS_WIDTH  destination byte address, word aligned.
- LENGTH  in  LENGTH_WIDTH  number of words to copy.
- DONE  out  1  copy complete; held until START drops.
- BUSY  out  1  high in RD or WR.
- AVM_AVALONMASTER_ADDRESS  out  ADDRESS_WIDTH  byte address.
- AVM_AVALONMASTER_READ  out  1  read strobe.
- AVM_AVALONMASTER_WRITE  out  1  write strobe.
- AVM_AVALONMASTER_WAITREQUEST  in  1  slave stall.
- AVM_AVALONMASTER_READDATA  in  DATA_WIDTH  read data; valid in the cycle READ=1 and WAITREQUEST=0.
- AVM_AVALONMASTER_WRITEDATA  out  DATA_WIDTH  write data.

Behaviour:
- Reset (CSI_CLOCK_RESET_N=0 at a clock edge): state IDLE; READ=0, WRITE=0, DONE=0, BUSY=0; ADDRESS=0, WRITEDATA=0; internal src/dst/count/data registers = 0.
- Reset mid-transfer: strobes drop at that same edge; the transfer is abandoned with no completion indication.
- State IDLE:
  - START=1 and LENGTH!=0: latch SRC_ADDR→src, DST_ADDR→dst, LENGTH→count; go to RD.
  - START=1 and LENGTH==0: go directly to FIN, with no bus activity.
- State RD:
  - Drive READ=1, ADDRESS=src.
  - WAITREQUEST=1: hold ADDRESS and READ stable.
  - WAITREQUEST=0: capture READDATA into the data register; src += stride; go to WR.
  - Minimum one cycle per read.
- State WR:
  - Drive WRITE=1, ADDRESS=dst, WRITEDATA=data register.
  - WAITREQUEST=1: hold ADDRESS, WRITE and WRITEDATA stable.
  - WAITREQUEST=0: dst += stride; count -= 1; if the old count==1 go to FIN, else go to RD.
- State FIN:
  - DONE=1, BUSY=0.
  - Stay while START=1. START=0 → IDLE; DONE clears in the IDLE cycle.
  - A new copy requires START to go 0 then 1 (no retrigger on a held level).
- READ and WRITE are never high in the same cycle. Strobes are registered outputs driven from state.
- START dropping during RD/WR is ignored; the copy always finishes.
- SRC_ADDR/DST_ADDR/LENGTH changes after the IDLE→RD edge have no effect.
- Address arithmetic is modulo 2^ADDRESS_WIDTH: wrap past 0xFFFFFFFC to 0x00000000 without error.
- Overlapping regions are not checked. Word-sequential ascending order is guaranteed.
- Throughput: 2 cycles per word with zero wait states. First READ is asserted the cycle after START is sampled.

Optional Feature:
- Macro AVM_COPY_CHECKSUM_EN.
- When defined:
  - Extra output CHECKSUM, DATA_WIDTH bits: modular sum of every word captured in RD during the current copy.
  - Cleared to 0 on the IDLE→RD or IDLE→FIN transition and on reset.
  - Stable and valid whenever DONE=1.
- When undefined: the port and the accumulator are absent; all other behaviour is identical.

Test Plan:
- Basic copy, no waits: SRC=0x100, DST=0x200, LENGTH=3, memory [0x100..0x108]={0xA,0xB,0xC}.
  - Expected bus sequence: R100, W200=0xA, R104, W204=0xB, R108, W208=0xC.
  - DONE=1 exactly 6 cycles after the first READ; CHECKSUM=0x21.
- Wait states: WAITREQUEST held high 3 cycles on each access, LENGTH=2.
  - Address, strobe and WRITEDATA stable during every stall.
  - 4 transactions total; DONE after 16 bus cycles.
- Zero length: LENGTH=0, START=1 → no READ/WRITE asserted, DONE=1 next cycle.
  - START=0 → DONE=0 the following cycle.
- Handshake/retrigger: START held at 1 after DONE → stays in FIN with no new reads.
  - START 0→1 with LENGTH=1 → exactly one new read/write pair.
- Wrap and reset: SRC=0xFFFFFFFC, LENGTH=2 → second read at 0x00000000.
  - Then assert CSI_CLOCK_RESET_N=0 during a stalled WR → WRITE=0, BUSY=0, DONE=0 at that edge; ADDRESS=0.

Source files
------------

// File: rtl/avm_copy_master.sv
// avm_copy_master: Avalon-MM block copy master, one read then one write per word.
// Optional CHECKSUM output enabled by defining AVM_COPY_CHECKSUM_EN.
module avm_copy_master #(
  parameter int AVM_AVALONMASTER_DATA_WIDTH    = 32,
  parameter int AVM_AVALONMASTER_ADDRESS_WIDTH = 32,
  parameter int LENGTH_WIDTH                   = 16
) (
  input  logic                                      CSI_CLOCK_CLK,
  input  logic                                      CSI_CLOCK_RESET_N,
  input  logic                                      START,
  input  logic [AVM_AVALONMASTER_ADDRESS_WIDTH-1:0] SRC_ADDR,
  input  logic [AVM_AVALONMASTER_ADDRESS_WIDTH-1:0] DST_ADDR,
  input  logic [LENGTH_WIDTH-1:0]                   LENGTH,
  output logic                                      DONE,
  output logic                                      BUSY,
`ifdef AVM_COPY_CHECKSUM_EN
  output logic [AVM_AVALONMASTER_DATA_WIDTH-1:0]    CHECKSUM,
`endif
  output logic [AVM_AVALONMASTER_ADDRESS_WIDTH-1:0] AVM_AVALONMASTER_ADDRESS,
  output logic                                      AVM_AVALONMASTER_READ,
  output logic                                      AVM_AVALONMASTER_WRITE,
  input  logic                                      AVM_AVALONMASTER_WAITREQUEST,
  input  logic [AVM_AVALONMASTER_DATA_WIDTH-1:0]    AVM_AVALONMASTER_READDATA,
  output logic [AVM_AVALONMASTER_DATA_WIDTH-1:0]    AVM_AVALONMASTER_WRITEDATA
);
  localparam int AW = AVM_AVALONMASTER_ADDRESS_WIDTH;
  localparam logic [AW-1:0] STRIDE = AW'(AVM_AVALONMASTER_DATA_WIDTH / 8);
  typedef enum logic [1:0] {IDLE, RD, WR, FIN} state_t;
  state_t state;
  logic [AW-1:0] src, dst;
  logic [LENGTH_WIDTH-1:0] count;
  // WRITEDATA doubles as the data register holding the word in flight
  always_ff @(posedge CSI_CLOCK_CLK) begin
    if (!CSI_CLOCK_RESET_N) begin
      state                      <= IDLE;
      src                        <= '0;
      dst                        <= '0;
      count                      <= '0;
      DONE                       <= 1'b0;
      BUSY                       <= 1'b0;
      AVM_AVALONMASTER_ADDRESS   <= '0;
      AVM_AVALONMASTER_READ      <= 1'b0;
      AVM_AVALONMASTER_WRITE     <= 1'b0;
      AVM_AVALONMASTER_WRITEDATA <= '0;
`ifdef AVM_COPY_CHECKSUM_EN
      CHECKSUM                   <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (START) begin
`ifdef AVM_COPY_CHECKSUM_EN
          CHECKSUM <= '0;
`endif
          if (LENGTH != '0) begin
            state                    <= RD;
            src                      <= SRC_ADDR;
            dst                      <= DST_ADDR;
            count                    <= LENGTH;
            BUSY                     <= 1'b1;
            AVM_AVALONMASTER_READ    <= 1'b1;
            AVM_AVALONMASTER_ADDRESS <= SRC_ADDR;
          end else begin
            state <= FIN;
            DONE  <= 1'b1;
          end
        end
        RD: if (!AVM_AVALONMASTER_WAITREQUEST) begin
          state                      <= WR;
          src                        <= src + STRIDE;
          AVM_AVALONMASTER_WRITEDATA <= AVM_AVALONMASTER_READDATA;
          AVM_AVALONMASTER_READ      <= 1'b0;
          AVM_AVALONMASTER_WRITE     <= 1'b1;
          AVM_AVALONMASTER_ADDRESS   <= dst;
`ifdef AVM_COPY_CHECKSUM_EN
          CHECKSUM                   <= CHECKSUM + AVM_AVALONMASTER_READDATA;
`endif
        end
        WR: if (!AVM_AVALONMASTER_WAITREQUEST) begin
          dst                    <= dst + STRIDE;
          count                  <= count - LENGTH_WIDTH'(1);
          AVM_AVALONMASTER_WRITE <= 1'b0;
          if (count == LENGTH_WIDTH'(1)) begin
            state <= FIN;
            DONE  <= 1'b1;
            BUSY  <= 1'b0;
          end else begin
            state                    <= RD;
            AVM_AVALONMASTER_READ    <= 1'b1;
            AVM_AVALONMASTER_ADDRESS <= src;
          end
        end
        FIN: if (!START) begin
          state <= IDLE;
          DONE  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_avm_copy_master.sv
// tb_avm_copy_master: directed tests for avm_copy_master against a simple memory slave.
module tb_avm_copy_master;
  logic clk = 0, rst_n = 0, start = 0;
  logic [31:0] src_addr = 0, dst_addr = 0;
  logic [15:0] length = 0;
  logic done, busy, rd, wr, waitreq;
  logic [31:0] addr, rdata, wdata;
`ifdef AVM_COPY_CHECKSUM_EN
  logic [31:0] checksum;
`endif
  logic [31:0] rom [0:1023];
  logic [64:0] tlog [0:127];
  logic [64:0] e [0:5];
  int wait_n = 0, stall = 0, tn = 0, unstable = 0, both_hi = 0;
  logic p_wait = 0, p_rd = 0, p_wr = 0;
  logic [31:0] p_addr = 0, p_wd = 0;
  int compared = 0, mismatched = 0, n, t0;

  avm_copy_master dut (
    .CSI_CLOCK_CLK(clk),
    .CSI_CLOCK_RESET_N(rst_n),
    .START(start),
    .SRC_ADDR(src_addr),
    .DST_ADDR(dst_addr),
    .LENGTH(length),
    .DONE(done),
    .BUSY(busy),
`ifdef AVM_COPY_CHECKSUM_EN
    .CHECKSUM(checksum),
`endif
    .AVM_AVALONMASTER_ADDRESS(addr),
    .AVM_AVALONMASTER_READ(rd),
    .AVM_AVALONMASTER_WRITE(wr),
    .AVM_AVALONMASTER_WAITREQUEST(waitreq),
    .AVM_AVALONMASTER_READDATA(rdata),
    .AVM_AVALONMASTER_WRITEDATA(wdata)
  );

  always #5 clk = ~clk;
  assign waitreq = (rd | wr) && stall < wait_n;
  assign rdata = rom[addr[11:2]];

  // slave: programmable wait states, transaction log and bus-protocol monitors
  always @(posedge clk) begin
    stall <= ((rd | wr) && stall < wait_n) ? stall + 1 : 0;
    if ((rd | wr) && !waitreq) begin
      tlog[tn[6:0]] <= {wr, addr, wr ? wdata : rdata};
      tn <= tn + 1;
    end
    if (rd && wr) both_hi <= both_hi + 1;
    if (rst_n && p_wait && (rd !== p_rd || wr !== p_wr || addr !== p_addr || (wr && wdata !== p_wd)))
      unstable <= unstable + 1;
    p_wait <= rst_n && waitreq;
    p_rd <= rd;
    p_wr <= wr;
    p_addr <= addr;
    p_wd <= wdata;
  end

  task tick;
    @(posedge clk);
    #1;
  endtask

  task wait_done;
    n = 0;
    while (!done && n < 200) begin
      tick;
      n++;
    end
  endtask

  task test_reset;
    rst_n = 0;
    tick;
    tick;
    compared++; if (rd !== 1'b0) begin mismatched++; $display("FAIL reset_read: got %b want 0", rd); end
    compared++; if (wr !== 1'b0) begin mismatched++; $display("FAIL reset_write: got %b want 0", wr); end
    compared++; if (done !== 1'b0) begin mismatched++; $display("FAIL reset_done: got %b want 0", done); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b want 0", busy); end
    compared++; if (addr !== 32'h0) begin mismatched++; $display("FAIL reset_addr: got %h want 0", addr); end
    compared++; if (wdata !== 32'h0) begin mismatched++; $display("FAIL reset_wdata: got %h want 0", wdata); end
    rst_n = 1;
    tick;
  endtask

  task test_basic;
    rom[64] = 32'hA; rom[65] = 32'hB; rom[66] = 32'hC;
    wait_n = 0;
    t0 = tn;
    src_addr = 32'h100; dst_addr = 32'h200; length = 3; start = 1;
    tick;
    compared++; if (rd !== 1'b1 || addr !== 32'h100) begin mismatched++; $display("FAIL basic_first_read: got rd=%b addr=%h want rd=1 addr=00000100", rd, addr); end
    compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL basic_busy: got %b want 1", busy); end
    src_addr = 32'hDEAD0000; dst_addr = 32'hBEEF0000; length = 7;
    wait_done;
    compared++; if (n !== 6) begin mismatched++; $display("FAIL basic_done_latency: got %0d want 6", n); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL basic_busy_fin: got %b want 0", busy); end
    compared++; if (tn - t0 !== 6) begin mismatched++; $display("FAIL basic_txn_count: got %0d want 6", tn - t0); end
    e[0] = {1'b0, 32'h100, 32'hA}; e[1] = {1'b1, 32'h200, 32'hA};
    e[2] = {1'b0, 32'h104, 32'hB}; e[3] = {1'b1, 32'h204, 32'hB};
    e[4] = {1'b0, 32'h108, 32'hC}; e[5] = {1'b1, 32'h208, 32'hC};
    for (int i = 0; i < 6; i++) begin
      compared++;
      if (tlog[t0 + i] !== e[i]) begin mismatched++; $display("FAIL basic_txn%0d: got %h want %h", i, tlog[t0 + i], e[i]); end
    end
`ifdef AVM_COPY_CHECKSUM_EN
    compared++; if (checksum !== 32'h21) begin mismatched++; $display("FAIL basic_checksum: got %h want 21", checksum); end
`endif
    start = 0;
    tick;
    compared++; if (done !== 1'b0) begin mismatched++; $display("FAIL basic_done_clear: got %b want 0", done); end
  endtask

  task test_wait_states;
    rom[80] = 32'h11; rom[81] = 32'h22;
    wait_n = 3;
    t0 = tn;
    src_addr = 32'h140; dst_addr = 32'h240; length = 2; start = 1;
    tick;
    wait_done;
    compared++; if (n !== 16) begin mismatched++; $display("FAIL wait_done_latency: got %0d want 16", n); end
    compared++; if (tn - t0 !== 4) begin mismatched++; $display("FAIL wait_txn_count: got %0d want 4", tn - t0); end
    e[0] = {1'b0, 32'h140, 32'h11}; e[1] = {1'b1, 32'h240, 32'h11};
    e[2] = {1'b0, 32'h144, 32'h22}; e[3] = {1'b1, 32'h244, 32'h22};
    for (int i = 0; i < 4; i++) begin
      compared++;
      if (tlog[t0 + i] !== e[i]) begin mismatched++; $display("FAIL wait_txn%0d: got %h want %h", i, tlog[t0 + i], e[i]); end
    end
    compared++; if (unstable !== 0) begin mismatched++; $display("FAIL wait_stable: got %0d unstable stalls want 0", unstable); end
`ifdef AVM_COPY_CHECKSUM_EN
    compared++; if (checksum !== 32'h33) begin mismatched++; $display("FAIL wait_checksum: got %h want 33", checksum); end
`endif
    start = 0;
    wait_n = 0;
    tick;
  endtask

  task test_zero_length;
    t0 = tn;
    length = 0; start = 1;
    tick;
    compared++; if (done !== 1'b1) begin mismatched++; $display("FAIL zero_done: got %b want 1", done); end
    compared++; if ({rd, wr, busy} !== 3'b000) begin mismatched++; $display("FAIL zero_no_bus: got rd/wr/busy=%b want 000", {rd, wr, busy}); end
`ifdef AVM_COPY_CHECKSUM_EN
    compared++; if (checksum !== 32'h0) begin mismatched++; $display("FAIL zero_checksum: got %h want 0", checksum); end
`endif
    repeat (3) tick;
    compared++; if (done !== 1'b1 || tn !== t0) begin mismatched++; $display("FAIL zero_hold: got done=%b txns=%0d want done=1 txns=0", done, tn - t0); end
    start = 0;
    tick;
    compared++; if (done !== 1'b0) begin mismatched++; $display("FAIL zero_done_clear: got %b want 0", done); end
  endtask

  task test_retrigger;
    rom[96] = 32'h5A; rom[97] = 32'h77;
    t0 = tn;
    src_addr = 32'h180; dst_addr = 32'h280; length = 1; start = 1;
    wait_done;
    compared++; if (n !== 3) begin mismatched++; $display("FAIL retrig_first_latency: got %0d want 3", n); end
    repeat (10) tick;
    compared++; if (done !== 1'b1) begin mismatched++; $display("FAIL retrig_held_done: got %b want 1", done); end
    compared++; if (tn - t0 !== 2) begin mismatched++; $display("FAIL retrig_no_rerun: got %0d txns want 2", tn - t0); end
    start = 0;
    tick;
    src_addr = 32'h184; dst_addr = 32'h284; start = 1;
    wait_done;
    compared++; if (n !== 3) begin mismatched++; $display("FAIL retrig_second_latency: got %0d want 3", n); end
    compared++; if (tn - t0 !== 4) begin mismatched++; $display("FAIL retrig_txn_count: got %0d want 4", tn - t0); end
    compared++; if (tlog[t0 + 2] !== {1'b0, 32'h184, 32'h77}) begin mismatched++; $display("FAIL retrig_read: got %h want %h", tlog[t0 + 2], {1'b0, 32'h184, 32'h77}); end
    compared++; if (tlog[t0 + 3] !== {1'b1, 32'h284, 32'h77}) begin mismatched++; $display("FAIL retrig_write: got %h want %h", tlog[t0 + 3], {1'b1, 32'h284, 32'h77}); end
`ifdef AVM_COPY_CHECKSUM_EN
    compared++; if (checksum !== 32'h77) begin mismatched++; $display("FAIL retrig_checksum: got %h want 77", checksum); end
`endif
    start = 0;
    tick;
  endtask

  task test_wrap_reset;
    rom[1023] = 32'h1234; rom[0] = 32'h5678;
    wait_n = 0;
    t0 = tn;
    src_addr = 32'hFFFFFFFC; dst_addr = 32'h300; length = 2; start = 1;
    repeat (4) tick;
    wait_n = 100;
    compared++; if (wr !== 1'b1 || addr !== 32'h304) begin mismatched++; $display("FAIL wrap_second_write: got wr=%b addr=%h want wr=1 addr=00000304", wr, addr); end
    compared++; if (tlog[t0] !== {1'b0, 32'hFFFFFFFC, 32'h1234}) begin mismatched++; $display("FAIL wrap_first_read: got %h want %h", tlog[t0], {1'b0, 32'hFFFFFFFC, 32'h1234}); end
    compared++; if (tlog[t0 + 2] !== {1'b0, 32'h0, 32'h5678}) begin mismatched++; $display("FAIL wrap_second_read: got %h want %h", tlog[t0 + 2], {1'b0, 32'h0, 32'h5678}); end
    tick;
    tick;
    compared++; if (wr !== 1'b1 || wdata !== 32'h5678) begin mismatched++; $display("FAIL wrap_stalled: got wr=%b wdata=%h want wr=1 wdata=00005678", wr, wdata); end
    rst_n = 0;
    start = 0;
    tick;
    compared++; if ({rd, wr, busy, done} !== 4'b0000) begin mismatched++; $display("FAIL reset_mid_xfer: got rd/wr/busy/done=%b want 0000", {rd, wr, busy, done}); end
    compared++; if (addr !== 32'h0) begin mismatched++; $display("FAIL reset_mid_addr: got %h want 0", addr); end
    wait_n = 0;
    rst_n = 1;
    repeat (4) tick;
    compared++; if (done !== 1'b0 || tn - t0 !== 3) begin mismatched++; $display("FAIL reset_abandon: got done=%b txns=%0d want done=0 txns=3", done, tn - t0); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = 32'h0;
    test_reset;
    test_basic;
    test_wait_states;
    test_zero_length;
    test_retrigger;
    test_wrap_reset;
    compared++; if (both_hi !== 0) begin mismatched++; $display("FAIL read_write_exclusive: got %0d overlapping cycles want 0", both_hi); end
    compared++; if (unstable !== 0) begin mismatched++; $display("FAIL stall_stability: got %0d unstable stalls want 0", unstable); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
